ahb_slave_mem: RTL and testbench

AHB-Lite responder providing a 2^DEPTH_LOG2 × 32-bit memory window at BASE_ADDR. It is the slave end of the bridge's AHB master: it samples the pipelined address phase, inserts a programmable number of wait states, and commits writes or returns read data in the data phase. Out-of-window accesses get a two-cycle ERROR response when the error feature is compiled in.

---
 rtl/ahb_bridge_pkg.sv | 41 ++++
 rtl/ahb_slv_regfile.sv | 33 +++
 rtl/ahb_slave_mem.sv | 152 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the bridge codebase.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package ahb_bridge_pkg;

  // htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // hresp encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Slave data-phase FSM.
  //   IDLE : no data phase pending
  //   WAIT : wait-state countdown (hr_readyout low)
  //   DATA : final data-phase cycle (hr_readyout high)
  //   ERR1 : first ERROR cycle (hr_readyout low)
  //   ERR2 : second ERROR cycle (hr_readyout high)
  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

  // Attributes of a sampled address phase that matter in the data phase.
  typedef struct packed {
    logic write;
    logic hit;
  } slv_cmd_t;

  // NONSEQ and SEQ start a data phase; IDLE and BUSY do not.
  function automatic logic trans_is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slv_regfile.sv
// Word memory behind the AHB slave: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge with wen high; read is combinational from raddr.
// Backpressure: none; the owning FSM decides when to write.
module ahb_slv_regfile #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  // Storage: cleared asynchronously by reset, otherwise one word written per enabled edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave exposing a 2^DEPTH_LOG2 x 32-bit memory window at BASE_ADDR.
// Latency: data phase lasts WAIT_STATES+1 cycles; out-of-window accesses get a 2-cycle ERROR.
// Backpressure: hr_readyout low during wait states and ERR1; optional ERROR path under AHB_SLV_ERR_EN.
module ahb_slave_mem
  import ahb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8400_0000,
  parameter int          DEPTH_LOG2  = 4,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hr_readyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp
);

  // Counter is 3 bits wide because WAIT_STATES is limited to 0..7.
  localparam logic [2:0]               WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [31-DEPTH_LOG2:0]   BASE_TAG  = BASE_ADDR[31:DEPTH_LOG2];

  slv_state_e            state;
  slv_state_e            state_nxt;
  logic [2:0]            cnt;
  logic [2:0]            cnt_nxt;
  slv_cmd_t              cap_cmd;
  logic [DEPTH_LOG2-1:0] cap_idx;

  logic                  xfer_vld;
  logic                  addr_hit;
  logic                  mem_wen;
  logic [31:0]           mem_rdata;

  // A transfer is only taken when the bus is ready and htrans is NONSEQ/SEQ;
  // whether the slave itself is able to sample is decided by the FSM state.
  assign xfer_vld = hreadyin && trans_is_active(htrans);
  assign addr_hit = (haddr[31:DEPTH_LOG2] == BASE_TAG);

  // State register: FSM state, wait counter and the captured address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= SLV_IDLE;
      cnt     <= '0;
      cap_cmd <= '0;
      cap_idx <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Capture only in states that present hr_readyout=1 and only for a real transfer.
      if ((state_nxt != SLV_IDLE) && (state == SLV_IDLE || state == SLV_DATA || state == SLV_ERR2)) begin
        cap_cmd.write <= hwrite;
        cap_cmd.hit   <= addr_hit;
        cap_idx       <= haddr[DEPTH_LOG2-1:0];
      end
    end
  end

  // Next-state logic: countdown in WAIT, fixed ERR1->ERR2 step, address sampling elsewhere.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SLV_WAIT: begin
        // Leaving at a count of 1 gives exactly WAIT_STATES low-ready cycles.
        if (cnt <= 3'd1) begin
          state_nxt = SLV_DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
`ifdef AHB_SLV_ERR_EN
      SLV_ERR1: begin
        state_nxt = SLV_ERR2;
        cnt_nxt   = '0;
      end
`endif
      default: begin
        // IDLE, DATA and ERR2 all drive hr_readyout=1, so the next address phase is live.
        if (xfer_vld) begin
`ifdef AHB_SLV_ERR_EN
          if (!addr_hit) begin
            state_nxt = SLV_ERR1;
            cnt_nxt   = '0;
          end else
`endif
          if (WAIT_LOAD != 3'd0) begin
            state_nxt = SLV_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = SLV_DATA;
            cnt_nxt   = '0;
          end
        end else begin
          state_nxt = SLV_IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Output logic: decoded purely from registered state, so no input-to-output path exists.
  always_comb begin
    hr_readyout = 1'b1;
    hresp       = HRESP_OKAY;
    hrdata      = '0;
    mem_wen     = 1'b0;
    case (state)
      SLV_WAIT: begin
        hr_readyout = 1'b0;
        // Misses only reach WAIT/DATA when the ERROR path is compiled out; they read as zero.
        hrdata      = cap_cmd.hit ? mem_rdata : '0;
      end
      SLV_DATA: begin
        hrdata  = cap_cmd.hit ? mem_rdata : '0;
        // The write lands on the edge that ends DATA, which is also the edge that
        // samples the next address phase, so a following read sees the new value.
        mem_wen = cap_cmd.write && cap_cmd.hit;
      end
`ifdef AHB_SLV_ERR_EN
      SLV_ERR1: begin
        hr_readyout = 1'b0;
        hresp       = HRESP_ERROR;
      end
      SLV_ERR2: begin
        hresp = HRESP_ERROR;
      end
`endif
      default: begin
        hr_readyout = 1'b1;
      end
    endcase
  end

  ahb_slv_regfile #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_regfile (
    .hclk    (hclk),
    .hresetn (hresetn),
    .wen     (mem_wen),
    .waddr   (cap_idx),
    .wdata   (hwdata),
    .raddr   (cap_idx),
    .rdata   (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 2 wait states) driven by an AHB master
// model; a transaction-level reference predicts every output cycle and one compare
// process checks it, with a few literal expectations pinning the reference.
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE  = 32'h8400_0000;
  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        rd_end;
  } exp_t;

  logic        hclk;
  logic        hresetn;
  logic        hwrite_s   [2];
  logic        hreadyin_s [2];
  logic [1:0]  htrans_s   [2];
  logic [31:0] haddr_s    [2];
  logic [31:0] hwdata_s   [2];
  logic        rdy_s      [2];
  logic [31:0] rdata_s    [2];
  logic [1:0]  resp_s     [2];

  ahb_slave_mem #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite_s[0]), .hreadyin(hreadyin_s[0]),
    .htrans(htrans_s[0]), .haddr(haddr_s[0]), .hwdata(hwdata_s[0]),
    .hr_readyout(rdy_s[0]), .hrdata(rdata_s[0]), .hresp(resp_s[0]));

  ahb_slave_mem #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite_s[1]), .hreadyin(hreadyin_s[1]),
    .htrans(htrans_s[1]), .haddr(haddr_s[1]), .hwdata(hwdata_s[1]),
    .hr_readyout(rdy_s[1]), .hrdata(rdata_s[1]), .hresp(resp_s[1]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Reference model state
  exp_t        exp_q    [2][$];
  item_t       items    [2][$];
  item_t       cur      [2];
  logic        cur_done [2];
  logic        cur_real [2];
  logic [31:0] mem_m    [2][DEPTH];
  logic        pend_vld [2];
  int          pend_idx [2];
  logic [31:0] pend_dat [2];
  logic [31:0] dph_wdata[2];
  bit          rnd_mode;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          low_cnt  [2];
  int          err_cnt  [2];
  logic [31:0] rd_dat   [2][$];
  int          rd_cyc   [2][$];
  exp_t        ce;
  item_t       ri;

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", nm, k, cyc, act, expv);
    end
  endtask

  task automatic push_exp(int k, logic rdy, logic [1:0] resp, logic [31:0] rdata, logic rd_end);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.rdata = rdata; e.rd_end = rd_end;
    exp_q[k].push_back(e);
  endtask

  // A transfer accepted by the slave: predict every cycle of its data phase.
  task automatic accept(int k, item_t it);
    int          idx;
    bit          hit;
    logic [31:0] rv;
    idx = int'(it.addr % 32'(DEPTH));
    hit = ((it.addr / 32'(DEPTH)) == (BASE / 32'(DEPTH)));
    if (!hit && ERR_EN) begin
      push_exp(k, 1'b0, 2'b01, 32'h0, 1'b0);
      push_exp(k, 1'b1, 2'b01, 32'h0, 1'b0);
    end else begin
      rv = hit ? mem_m[k][idx] : 32'h0;
      for (int i = 0; i < ws_of(k); i++) push_exp(k, 1'b0, 2'b00, rv, 1'b0);
      push_exp(k, 1'b1, 2'b00, rv, !it.wr);
      if (it.wr && hit) begin
        pend_vld[k] = 1'b1;
        pend_idx[k] = idx;
        pend_dat[k] = it.data;
      end
    end
    dph_wdata[k] = it.wr ? it.data : $urandom();
  endtask

  // Model step at a rising edge, using the inputs presented during the cycle just ended.
  task automatic bus_edge(int k);
    if (!hresetn) begin
      exp_q[k].delete();
      pend_vld[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 32'h0;
      return;
    end
    if (exp_q[k].size() == 0) begin
      // Slave was ready: an outstanding write completes, then the address phase is seen.
      if (pend_vld[k]) begin
        mem_m[k][pend_idx[k]] = pend_dat[k];
        pend_vld[k] = 1'b0;
      end
      if (hreadyin_s[k]) begin
        if (cur[k].trans[1]) accept(k, cur[k]);
        else push_exp(k, 1'b1, 2'b00, 32'h0, 1'b0);
        cur_done[k] = 1'b1;
        cur_real[k] = 1'b0;
      end else begin
        push_exp(k, 1'b1, 2'b00, 32'h0, 1'b0);
      end
    end
  endtask

  task automatic present(int k);
    if (cur_done[k]) begin
      if (items[k].size() > 0) begin
        cur[k] = items[k].pop_front();
        cur_real[k] = 1'b1;
      end else begin
        cur[k].trans = 2'b00;
        cur[k].wr    = 1'($urandom_range(0, 1));
        cur[k].addr  = $urandom();
        cur[k].data  = $urandom();
      end
      cur_done[k] = 1'b0;
    end
    htrans_s[k]   = cur[k].trans;
    hwrite_s[k]   = cur[k].wr;
    haddr_s[k]    = cur[k].addr;
    hreadyin_s[k] = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    hwdata_s[k]   = dph_wdata[k];
  endtask

  // Master + model process
  initial begin
    forever begin
      @(posedge hclk);
      for (int k = 0; k < 2; k++) bus_edge(k);
      #2;
      for (int k = 0; k < 2; k++) present(k);
    end
  end

  // Compare process: every cycle, both instances.
  initial begin
    forever begin
      @(posedge hclk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!hresetn) begin
          chk("rst_ready", k, 32'(rdy_s[k]), 32'h1);
          chk("rst_resp",  k, 32'(resp_s[k]), 32'h0);
          chk("rst_rdata", k, rdata_s[k], 32'h0);
        end else if (exp_q[k].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL no_expectation[%0d] cycle %0d: got empty, required one entry", k, cyc);
        end else begin
          ce = exp_q[k].pop_front();
          chk("ready", k, 32'(rdy_s[k]), 32'(ce.rdy));
          chk("resp",  k, 32'(resp_s[k]), 32'(ce.resp));
          chk("rdata", k, rdata_s[k], ce.rdata);
          if (ce.rd_end) begin
            rd_dat[k].push_back(rdata_s[k]);
            rd_cyc[k].push_back(cyc);
          end
          if (!rdy_s[k]) low_cnt[k]++;
          if (resp_s[k] == 2'b01) err_cnt[k]++;
        end
      end
    end
  end

  task automatic add_item(int k, logic [1:0] trans, logic wr, logic [31:0] addr, logic [31:0] data);
    item_t it;
    it.trans = trans; it.wr = wr; it.addr = addr; it.data = data;
    items[k].push_back(it);
  endtask

  task automatic wait_drain(int k);
    int t;
    t = 0;
    while ((items[k].size() != 0 || cur_real[k] || exp_q[k].size() != 0) && t < 4000) begin
      @(posedge hclk);
      #3;
      t++;
    end
    if (t >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout[%0d]: got %0d cycles, required under 4000", k, t);
    end
    repeat (2) @(posedge hclk);
    #3;
  endtask

  task automatic clear_logs(int k);
    rd_dat[k].delete();
    rd_cyc[k].delete();
    low_cnt[k] = 0;
    err_cnt[k] = 0;
  endtask

  logic [31:0] incr_v [4];
  int          t_poll;

  initial begin
    hresetn = 1'b0;
    rnd_mode = 1'b0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      cur_done[k] = 1'b1; cur_real[k] = 1'b0; pend_vld[k] = 1'b0; dph_wdata[k] = 32'h0;
      low_cnt[k] = 0; err_cnt[k] = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 32'h0;
      present(k);
    end
    incr_v[0] = 32'h11; incr_v[1] = 32'h22; incr_v[2] = 32'h33; incr_v[3] = 32'h44;

    // Reset for two cycles, then idle.
    repeat (2) @(posedge hclk);
    #2 hresetn = 1'b1;
    repeat (3) @(posedge hclk);
    #3;

    // Single write then read, no wait states.
    clear_logs(0);
    add_item(0, 2'b10, 1'b1, 32'h8400_0000, 32'h29);
    add_item(0, 2'b10, 1'b0, 32'h8400_0000, 32'h0);
    wait_drain(0);
    chk("wr_rd_value", 0, (rd_dat[0].size() > 0) ? rd_dat[0][$] : 32'hDEAD_0000, 32'h29);
    chk("wr_rd_nowait", 0, 32'(low_cnt[0]), 32'h0);

    // INCR4 write then read back.
    clear_logs(0);
    for (int i = 0; i < 4; i++) add_item(0, (i == 0) ? 2'b10 : 2'b11, 1'b1, BASE + 32'(i), incr_v[i]);
    for (int i = 0; i < 4; i++) add_item(0, (i == 0) ? 2'b10 : 2'b11, 1'b0, BASE + 32'(i), 32'h0);
    wait_drain(0);
    chk("incr4_count", 0, 32'(rd_dat[0].size()), 32'h4);
    if (rd_dat[0].size() == 4) begin
      for (int i = 0; i < 4; i++) chk("incr4_data", 0, rd_dat[0][i], incr_v[i]);
      for (int i = 1; i < 4; i++) chk("incr4_gap", 0, 32'(rd_cyc[0][i] - rd_cyc[0][i-1]), 32'h1);
    end

    // Two wait states: single read after a write.
    add_item(1, 2'b10, 1'b1, 32'h8400_0003, 32'hA5A5_0003);
    wait_drain(1);
    clear_logs(1);
    add_item(1, 2'b10, 1'b0, 32'h8400_0003, 32'h0);
    wait_drain(1);
    chk("ws2_low_cycles", 1, 32'(low_cnt[1]), 32'h2);
    chk("ws2_rdata", 1, (rd_dat[1].size() > 0) ? rd_dat[1][$] : 32'hDEAD_0000, 32'hA5A5_0003);

    // Out-of-window write must not disturb index 0.
    add_item(1, 2'b10, 1'b1, 32'h8400_0000, 32'h77);
    wait_drain(1);
    clear_logs(1);
    add_item(1, 2'b10, 1'b1, 32'h8500_0000, 32'hDEAD_BEEF);
    wait_drain(1);
    chk("oow_err_cycles", 1, 32'(err_cnt[1]), ERR_EN ? 32'h2 : 32'h0);
    chk("oow_low_cycles", 1, 32'(low_cnt[1]), ERR_EN ? 32'h1 : 32'h2);
    clear_logs(1);
    add_item(1, 2'b10, 1'b0, 32'h8400_0000, 32'h0);
    wait_drain(1);
    chk("oow_prior_value", 1, (rd_dat[1].size() > 0) ? rd_dat[1][$] : 32'hDEAD_0000, 32'h77);

    // Reset during the wait states of a write.
    add_item(1, 2'b10, 1'b1, 32'h8400_0005, 32'h55);
    t_poll = 0;
    while (exp_q[1].size() != 2 && t_poll < 50) begin
      @(posedge hclk);
      #3;
      t_poll++;
    end
    chk("pre_reset_in_wait", 1, 32'(rdy_s[1]), 32'h0);
    hresetn = 1'b0;
    #1;
    chk("async_rst_ready", 1, 32'(rdy_s[1]), 32'h1);
    chk("async_rst_resp",  1, 32'(resp_s[1]), 32'h0);
    chk("async_rst_rdata", 1, rdata_s[1], 32'h0);
    @(posedge hclk);
    #2 hresetn = 1'b1;
    repeat (2) @(posedge hclk);
    #3;
    clear_logs(1);
    add_item(1, 2'b10, 1'b0, 32'h8400_0005, 32'h0);
    wait_drain(1);
    chk("dropped_write", 1, (rd_dat[1].size() > 0) ? rd_dat[1][$] : 32'hDEAD_0000, 32'h0);

    // Randomized traffic on both instances with random bus stalls.
    rnd_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 2; k++) begin
        ri.trans = 2'($urandom_range(0, 3));
        ri.wr    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0:       ri.addr = 32'h8500_0000 + 32'($urandom_range(0, 15));
          1:       ri.addr = $urandom();
          default: ri.addr = BASE + 32'($urandom_range(0, 15));
        endcase
        ri.data = $urandom();
        items[k].push_back(ri);
      end
    end
    wait_drain(0);
    wait_drain(1);
    rnd_mode = 1'b0;
    repeat (3) @(posedge hclk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
